// File: rtl/video_char_fetch.sv
// Text-mode char fetch: VRAM code -> char ROM glyph -> prefetch -> MSB-first pixel shifter (VIDEO_CHAR_FETCH_PIXEL_DOUBLE_EN doubles each bit).
// Latency: prefetch full 4 clocks after line_start; pixel updates 1 clock after pix_ce; refill 5 clocks after the prefetch is taken.
// Backpressure: fetch FSM stalls in FULL until the shifter takes the prefetch; a starved shifter outputs 0 and sets sticky underrun.
module video_char_fetch #(
    parameter int COLS = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        active,
    input  logic        line_start,
    input  logic [3:0]  char_row,
    input  logic [2:0]  scan_row,
    output logic [9:0]  vram_addr,
    input  logic [7:0]  vram_data,
    output logic [10:0] crom_addr,
    input  logic [7:0]  crom_data,
    output logic        pixel,
    output logic        underrun
);

`ifdef VIDEO_CHAR_FETCH_PIXEL_DOUBLE_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 3;
`endif
    localparam logic [CNT_W-1:0] CNT_LOAD = '1;
    localparam logic [6:0]       COLS_END = 7'(COLS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VWAIT = 3'd1,
        VDATA = 3'd2,
        CWAIT = 3'd3,
        CDATA = 3'd4,
        FULL  = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]       row_q;
    logic [2:0]       scan_q;
    logic [6:0]       col;
    logic [7:0]       pf_dat;
    logic             pf_vld;
    logic [7:0]       sh_dat;
    logic [CNT_W-1:0] sh_cnt;

    logic             line_end;
    logic             vaddr_ld;
    logic             caddr_ld;
    logic             pf_ld;
    logic             shift_ce;
    logic             starve;
    logic             sh_step;
    logic [7:0]       sh_load;

    assign line_end = (col == COLS_END);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; line_start restarts the sequence from any state
    always_comb begin
        state_nxt = state;
        if (line_start) begin
            state_nxt = VWAIT;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                VWAIT:   state_nxt = VDATA;
                VDATA:   state_nxt = CWAIT;
                CWAIT:   state_nxt = CDATA;
                CDATA:   state_nxt = FULL;
                FULL: begin
                    if (!pf_vld) begin
                        state_nxt = line_end ? DONE : VWAIT;
                    end
                end
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM output strobes
    always_comb begin
        vaddr_ld = 1'b0;
        caddr_ld = 1'b0;
        pf_ld    = 1'b0;
        if (!line_start) begin
            case (state)
                FULL:    vaddr_ld = !pf_vld && !line_end;
                VDATA:   caddr_ld = 1'b1;
                CDATA:   pf_ld    = 1'b1;
                default: ;
            endcase
        end
    end

    // Shifter control; in doubled mode each bit is shown on two pix_ce before moving on
    always_comb begin
        shift_ce = pix_ce && !line_start;
        starve   = shift_ce && active && (sh_cnt == '0) && !pf_vld && (state != DONE);
`ifdef VIDEO_CHAR_FETCH_PIXEL_DOUBLE_EN
        sh_step  = sh_cnt[0];
        sh_load  = pf_dat;
`else
        sh_step  = 1'b1;
        sh_load  = {pf_dat[6:0], 1'b0};
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q     <= '0;
            scan_q    <= '0;
            col       <= '0;
            vram_addr <= '0;
            crom_addr <= '0;
            pf_dat    <= '0;
            pf_vld    <= 1'b0;
            sh_dat    <= '0;
            sh_cnt    <= '0;
            pixel     <= 1'b0;
        end else if (line_start) begin
            row_q     <= char_row;
            scan_q    <= scan_row;
            col       <= '0;
            vram_addr <= {char_row, 6'd0};
            pf_vld    <= 1'b0;
            sh_dat    <= '0;
            sh_cnt    <= '0;
            pixel     <= 1'b0;
        end else begin
            if (vaddr_ld) begin
                vram_addr <= {row_q, col[5:0]};
            end
            if (caddr_ld) begin
                crom_addr <= {vram_data, scan_q};
            end
            if (pf_ld) begin
                pf_dat <= crom_data;
                pf_vld <= 1'b1;
                col    <= col + 7'd1;
            end
            if (shift_ce) begin
                if (!active) begin
                    pixel <= 1'b0;
                end else if (sh_cnt != '0) begin
                    pixel  <= sh_dat[7];
                    sh_cnt <= sh_cnt - 1'b1;
                    if (sh_step) begin
                        sh_dat <= {sh_dat[6:0], 1'b0};
                    end
                end else if (pf_vld) begin
                    pixel  <= pf_dat[7];
                    sh_dat <= sh_load;
                    sh_cnt <= CNT_LOAD;
                    pf_vld <= 1'b0;
                end else begin
                    pixel <= 1'b0;
                end
            end
        end
    end

    // Past the last column (DONE) an empty shifter is expected, not a starvation
    always_ff @(posedge clock) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (starve) begin
            underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_char_fetch.sv
// Bench for video_char_fetch: random VRAM/ROM contents, per-clock check of pixel and underrun
// against a glyph bit-stream model built directly from the memory contents.
module tb_video_char_fetch;

`ifdef VIDEO_CHAR_FETCH_PIXEL_DOUBLE_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif
    localparam int COLS = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pix_ce = 1'b0;
    logic        active = 1'b0;
    logic        line_start = 1'b0;
    logic [3:0]  char_row = '0;
    logic [2:0]  scan_row = '0;
    logic [9:0]  vram_addr;
    logic [7:0]  vram_data = '0;
    logic [10:0] crom_addr;
    logic [7:0]  crom_data = '0;
    logic        pixel;
    logic        underrun;

    logic [7:0] vram [0:1023];
    logic [7:0] crom [0:2047];

    int n_chk  = 0;
    int n_fail = 0;

    bit   exp_q[$];
    bit   got_q[$];
    int   exp_idx;
    logic exp_pix;
    logic exp_unr;
    int   last_vcol;
    logic [9:0]  va_e0;
    logic [10:0] ca_e2;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        vram_data <= vram[vram_addr];
        crom_data <= crom[crom_addr];
    end

    video_char_fetch #(.COLS(COLS)) dut (
        .clock      (clock),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .active     (active),
        .line_start (line_start),
        .char_row   (char_row),
        .scan_row   (scan_row),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data),
        .crom_addr  (crom_addr),
        .crom_data  (crom_data),
        .pixel      (pixel),
        .underrun   (underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected pixel stream of a whole line: every glyph byte MSB first, each bit REP times
    task automatic build_stream(input logic [3:0] row, input logic [2:0] scan);
        logic [9:0] a;
        logic [7:0] g;
        exp_q.delete();
        for (int c = 0; c < COLS; c++) begin
            a = {row, 6'(c)};
            g = crom[{vram[a], scan}];
            for (int b = 7; b >= 0; b--) begin
                for (int r = 0; r < REP; r++) exp_q.push_back(g[b]);
            end
        end
    endtask

    // mode 0: pix_ce every clock, active from edge 5; mode 1: random pix_ce/active from edge 5;
    // mode 2: pix_ce and active every clock from edge 1 (starves until the first glyph arrives)
    task automatic run_line(input logic [3:0] row, input logic [2:0] scan, input int ncyc,
                            input int mode, input logic ls_pix);
        logic p;
        logic a;
        logic [9:0] prev_va;
        int vcol;
        build_stream(row, scan);
        got_q.delete();
        exp_idx    = 0;
        char_row   = row;
        scan_row   = scan;
        line_start = 1'b1;
        pix_ce     = ls_pix;
        active     = ls_pix;
        tick();
        line_start = 1'b0;
        exp_pix    = 1'b0;
        va_e0      = vram_addr;
        check("ls_pixel", pixel, exp_pix);
        check("ls_vaddr", vram_addr, {row, 6'd0});
        check("ls_underrun", underrun, exp_unr);
        prev_va = vram_addr;
        vcol    = 1;
        for (int k = 1; k < ncyc; k++) begin
            case (mode)
                0:       begin p = 1'b1; a = (k >= 5); end
                1:       begin p = ($urandom_range(0, 2) != 0); a = (k >= 5) && ($urandom_range(0, 3) != 0); end
                default: begin p = 1'b1; a = 1'b1; end
            endcase
            pix_ce = p;
            active = a;
            tick();
            if (p) begin
                if (!a) begin
                    exp_pix = 1'b0;
                end else if (k < 5) begin
                    exp_pix = 1'b0;
                    exp_unr = 1'b1;
                end else if (exp_idx < exp_q.size()) begin
                    exp_pix = exp_q[exp_idx];
                    exp_idx++;
                end else begin
                    exp_pix = 1'b0;
                end
                if (a && k >= 5) got_q.push_back(pixel);
            end
            check("pixel", pixel, exp_pix);
            check("underrun", underrun, exp_unr);
            if (k == 2) begin
                ca_e2 = crom_addr;
                check("caddr_e2", crom_addr, {vram[{row, 6'd0}], scan});
            end
            if (vram_addr != prev_va) begin
                check("vaddr_nowrap", (vcol < COLS), 1);
                check("vaddr_step", vram_addr, {row, 6'(vcol)});
                vcol++;
                prev_va = vram_addr;
            end
        end
        last_vcol = vcol;
        pix_ce = 1'b0;
        active = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        pix_ce = 1'b1;
        active = 1'b1;
        tick();
        reset   = 1'b0;
        active  = 1'b0;
        exp_pix = 1'b0;
        exp_unr = 1'b0;
        check("rst_pixel", pixel, 0);
        check("rst_vaddr", vram_addr, 0);
        check("rst_caddr", crom_addr, 0);
        check("rst_underrun", underrun, 0);
        for (int i = 0; i < 8; i++) begin
            pix_ce = 1'($urandom);
            tick();
            check("idle_vaddr", vram_addr, 0);
            check("idle_caddr", crom_addr, 0);
            check("idle_pixel", pixel, 0);
            check("idle_underrun", underrun, 0);
        end
        pix_ce = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        logic [3:0]  r;
        for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) crom[i] = 8'($urandom);
        exp_unr = 1'b0;
        exp_pix = 1'b0;
        tick();
        do_reset();

        // Single character with known glyph
        vram[{4'd3, 6'd0}] = 8'h41;
        crom[{8'h41, 3'd5}] = (REP == 1) ? 8'hA5 : 8'h81;
        run_line(4'd3, 3'd5, 40, 0, 1'b0);
        check("va_e0", va_e0, 10'h0C0);
        check("ca_e2", ca_e2, 11'h20D);
        w = '0;
        for (int i = 0; i < 8 * REP; i++) w = {w[14:0], got_q[i]};
        check("glyph_word", w, (REP == 1) ? 16'h00A5 : 16'hC003);

        // Full line at pixel rate, then trailing zeros
        r = 4'($urandom);
        run_line(r, 3'($urandom), 8 * REP * COLS + 20, 0, 1'b0);
        check("full_vcols", last_vcol, COLS);
        check("full_lastaddr", vram_addr, {r, 6'd63});
        check("full_consumed", exp_idx, 8 * REP * COLS);

        // Irregular pixel enables
        for (int n = 0; n < 2; n++) run_line(4'($urandom), 3'($urandom), 900 * REP, 1, 1'b0);

        // Restart mid-line at column 10, coincident with pix_ce
        run_line(4'($urandom), 3'($urandom), 5 + 8 * REP * 10, 0, 1'b0);
        run_line(4'($urandom), 3'($urandom), 200, 0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            run_line(4'($urandom), 3'($urandom), $urandom_range(6, 100), 0, 1'($urandom));
        end
        run_line(4'($urandom), 3'($urandom), 120, 0, 1'b1);

        // Reset mid-line
        run_line(4'($urandom), 3'($urandom), 40, 0, 1'b0);
        do_reset();

        // Starvation and sticky flag
        run_line(4'($urandom), 3'($urandom), 100, 2, 1'b0);
        check("unr_set", underrun, 1);
        run_line(4'($urandom), 3'($urandom), 60, 0, 1'b0);
        check("unr_sticky", underrun, 1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
